// File: rtl/tt_um_alu_dec.sv
// ---------------------------------------------------------------------------
// tt_um_alu_dec
//
// Stream decryptor and result buffer for the ALU's ENC operation. The ALU
// encrypts a packed operand byte as {a,b} ^ 8'hAB. This tile accepts bytes
// over a valid/ready handshake. Depending on the sampled mode it does one of
// four things:
//   00 decrypt          - push ui_in ^ key
//   01 key load         - key <= ui_in; nothing is pushed
//   10 passthrough      - push ui_in unchanged
//   11 rolling decrypt  - push ui_in ^ key, then rotate key left by one
// Results go into a 2-entry FIFO that the host drains at its own pace.
//
// Ports
//   clk      clock; all state changes on the rising edge
//   rst_n    asynchronous active-low reset
//   ena      tile enable (ignored)
//   ui_in    input byte (cipher, key or passthrough byte)
//   uio_in   [0] in_valid, [1] out_ready, [3:2] mode, [7:4] unused
//   uo_out   FIFO head byte while out_valid=1, otherwise 8'h00
//   uio_out  [7] out_valid, [6] in_ready, [5:4] FIFO count, [3:0] zero
//   uio_oe   constant 8'hF0 (upper nibble of uio drives status)
// ---------------------------------------------------------------------------
module tt_um_alu_dec #(
  parameter logic [7:0] DEFAULT_KEY = 8'hAB
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] MODE_DEC  = 2'b00;
  localparam logic [1:0] MODE_KEY  = 2'b01;
  localparam logic [1:0] MODE_PASS = 2'b10;
  localparam logic [1:0] MODE_ROLL = 2'b11;

  // Control decode
  logic       in_valid;
  logic       out_ready;
  logic [1:0] mode;

  assign in_valid  = uio_in[0];
  assign out_ready = uio_in[1];
  assign mode      = uio_in[3:2];

  // Tile enable and the spare control bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in[7:4]};

  // State
  logic [7:0] mem_q [2];
  logic [7:0] mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q,  count_d;
  logic [7:0] key_q,    key_d;

  // Handshake status is a function of registered count only, so in_ready
  // never loops back combinationally through out_ready or in_valid.
  logic in_ready;
  logic out_valid;
  logic accept;
  logic push;
  logic pop;
  logic [7:0] push_data;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & (mode != MODE_KEY);
  assign pop       = out_valid & out_ready;

  // Both decrypt modes use the key as it stood before this edge.
  assign push_data = (mode == MODE_PASS) ? ui_in : (ui_in ^ key_q);

  always_comb begin
    key_d = key_q;
    if (accept) begin
      case (mode)
        MODE_KEY:  key_d = ui_in;
        MODE_ROLL: key_d = {key_q[6:0], key_q[7]};
        default:   key_d = key_q;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage entries: each one loads only when the write pointer selects it.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mem
    always_comb begin
      mem_d[gi] = mem_q[gi];
      if (push && (wr_ptr_q == 1'(gi))) begin
        mem_d[gi] = push_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= 8'h00;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      key_q    <= DEFAULT_KEY;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      key_q    <= key_d;
    end
  end

  // Outputs
  assign uo_out  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign uio_out = {out_valid, in_ready, count_q, 4'b0000};
  assign uio_oe  = 8'hF0;

  // MODE_DEC is the default arm of the data mux; named for readability.
  logic unused_mode_dec;
  assign unused_mode_dec = &{1'b0, MODE_DEC};

endmodule

// File: tb/tb_tt_um_alu_dec.sv
module tb_tt_um_alu_dec;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  tt_um_alu_dec dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    $display("check %s obs=%h exp=%h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then sample 1 time unit after the edge.
  task automatic cyc(input logic [7:0] d, input logic v, input logic r, input logic [1:0] m);
    ui_in  = d;
    uio_in = {4'b0000, m, r, v};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h40);
    chk("rst_uio_oe", uio_oe, 8'hF0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    @(posedge clk);
    #1;
    chk("por_uo_out", uo_out, 8'h00);
    chk("por_uio_out", uio_out, 8'h40);
    chk("por_uio_oe", uio_oe, 8'hF0);
    rst_n = 1'b1;

    // Round trip: ENC(3,5) = 8'h35 ^ 8'hAB = 8'h9E
    cyc(8'h9E, 1'b1, 1'b1, 2'b00);
    chk("rt_data", uo_out, 8'h35);
    chk("rt_status", uio_out, 8'hD0);
    cyc(8'h00, 1'b0, 1'b1, 2'b00);
    chk("rt_pop_status", uio_out, 8'h40);
    chk("rt_pop_data", uo_out, 8'h00);

    // Key load then decrypt with the new key, then passthrough
    cyc(8'h0F, 1'b1, 1'b0, 2'b01);
    chk("kl_no_out", uio_out, 8'h40);
    chk("kl_uo_zero", uo_out, 8'h00);
    cyc(8'h3C, 1'b1, 1'b0, 2'b00);
    chk("kl_dec", uo_out, 8'h33);
    chk("kl_dec_status", uio_out, 8'hD0);
    cyc(8'h3C, 1'b1, 1'b1, 2'b10);
    chk("pass_data", uo_out, 8'h3C);
    chk("pass_status", uio_out, 8'hD0);
    cyc(8'h00, 1'b0, 1'b1, 2'b00);
    chk("pass_drain", uio_out, 8'h40);

    // Rolling key from reset
    do_reset();
    cyc(8'h00, 1'b1, 1'b1, 2'b11);
    chk("roll0", uo_out, 8'hAB);
    cyc(8'h00, 1'b1, 1'b1, 2'b11);
    chk("roll1", uo_out, 8'h57);
    cyc(8'h00, 1'b1, 1'b1, 2'b11);
    chk("roll2", uo_out, 8'hAE);
    chk("roll2_status", uio_out, 8'hD0);
    cyc(8'h00, 1'b0, 1'b1, 2'b00);
    chk("roll_drain", uio_out, 8'h40);

    // Full and backpressure; restore key to AB first
    cyc(8'hAB, 1'b1, 1'b0, 2'b01);
    cyc(8'h9E, 1'b1, 1'b0, 2'b00);
    chk("bp_cnt1", uio_out, 8'hD0);
    cyc(8'h9F, 1'b1, 1'b0, 2'b00);
    chk("bp_full", uio_out, 8'hA0);
    chk("bp_head", uo_out, 8'h35);
    cyc(8'hA0, 1'b1, 1'b0, 2'b00);
    chk("bp_hold", uio_out, 8'hA0);
    chk("bp_hold_head", uo_out, 8'h35);
    cyc(8'hA0, 1'b1, 1'b1, 2'b00);
    chk("bp_pop1", uo_out, 8'h34);
    chk("bp_pop1_status", uio_out, 8'hD0);
    cyc(8'hA0, 1'b1, 1'b1, 2'b00);
    chk("bp_pop2", uo_out, 8'h0B);
    chk("bp_pop2_status", uio_out, 8'hD0);
    cyc(8'h00, 1'b0, 1'b1, 2'b00);
    chk("bp_drain", uio_out, 8'h40);

    // Simultaneous push and pop at count=1
    cyc(8'h10, 1'b1, 1'b0, 2'b10);
    chk("sim_start", uo_out, 8'h10);
    cyc(8'h11, 1'b1, 1'b1, 2'b10);
    chk("sim1", uo_out, 8'h11);
    chk("sim1_status", uio_out, 8'hD0);
    cyc(8'h12, 1'b1, 1'b1, 2'b10);
    chk("sim2", uo_out, 8'h12);
    cyc(8'h13, 1'b1, 1'b1, 2'b10);
    chk("sim3", uo_out, 8'h13);
    cyc(8'h14, 1'b1, 1'b1, 2'b10);
    chk("sim4", uo_out, 8'h14);
    chk("sim4_status", uio_out, 8'hD0);
    cyc(8'h00, 1'b0, 1'b1, 2'b00);
    chk("sim_drain", uio_out, 8'h40);

    // Reset mid-operation with count=2 and a loaded key
    cyc(8'h0F, 1'b1, 1'b0, 2'b01);
    cyc(8'h55, 1'b1, 1'b0, 2'b10);
    cyc(8'h66, 1'b1, 1'b0, 2'b10);
    chk("mid_full", uio_out, 8'hA0);
    chk("mid_head", uo_out, 8'h55);
    do_reset();
    cyc(8'h9E, 1'b1, 1'b0, 2'b00);
    chk("mid_after", uo_out, 8'h35);
    chk("mid_after_status", uio_out, 8'hD0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
